// File: rtl/pll_reconfig_seq.sv
// Reprograms the SDRAM-clock PLL: 8 Avalon-MM writes, a PLL reset pulse, then waits for lock.
// Outputs are decoded from registered state, so reset clears them asynchronously.
module pll_reconfig_seq #(
   parameter int unsigned GAP_CYCLES   = 7,
   parameter int unsigned RST_CYCLES   = 8,
   parameter int unsigned LOCK_TIMEOUT = 5000000,
   parameter logic [31:0] CP_VAL       = 32'h1,
   parameter logic [31:0] BW_VAL       = 32'h7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] cfg_m,
   input  logic [31:0] cfg_k,
   input  logic [31:0] cfg_c0,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        mgmt_write,
   input  logic        mgmt_waitrequest,
   output logic        pll_reset,
   input  logic        locked
);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_PRST, S_LOCK} state_t;

   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
   localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] m_q, m_d, k_q, k_d, c0_q, c0_d;
   logic        error_q, error_d;
   logic        locked_m_q, locked_s_q;

   logic [5:0]  tbl_addr;
   logic [31:0] tbl_data;
   logic        lock_ok, lock_to;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         m_q        <= '0;
         k_q        <= '0;
         c0_q       <= '0;
         error_q    <= 1'b0;
         locked_m_q <= 1'b0;
         locked_s_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         m_q        <= m_d;
         k_q        <= k_d;
         c0_q       <= c0_d;
         error_q    <= error_d;
         locked_m_q <= locked;
         locked_s_q <= locked_m_q;
      end
   end

   always_comb begin
      tbl_addr = '0;
      tbl_data = '0;
      case (idx_q)
         3'd0: begin tbl_addr = 6'd0; tbl_data = 32'h0;     end
         3'd1: begin tbl_addr = 6'd4; tbl_data = m_q;       end
         3'd2: begin tbl_addr = 6'd7; tbl_data = k_q;       end
         3'd3: begin tbl_addr = 6'd3; tbl_data = 32'h10000; end
         3'd4: begin tbl_addr = 6'd5; tbl_data = c0_q;      end
         3'd5: begin tbl_addr = 6'd9; tbl_data = CP_VAL;    end
         3'd6: begin tbl_addr = 6'd8; tbl_data = BW_VAL;    end
         default: begin tbl_addr = 6'd2; tbl_data = 32'h0;  end
      endcase
   end

   // The first four LOCK cycles may still show a stale pre-reset lock through the synchroniser.
   assign lock_ok = (state_q == S_LOCK) && (cnt_q >= 32'd4) && locked_s_q;
   assign lock_to = (state_q == S_LOCK) && (cnt_q == LOCK_LAST);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      k_d     = k_q;
      c0_d    = c0_q;
      error_d = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = cfg_m;
               k_d     = cfg_k;
               c0_d    = cfg_c0;
               error_d = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!mgmt_waitrequest) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = S_PRST;
               end else begin
                  idx_d   = 3'(idx_q + 3'd1);
                  state_d = S_WRITE;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_PRST: begin
            if (cnt_q == RST_LAST) begin
               cnt_d   = '0;
               state_d = S_LOCK;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_LOCK: begin
            if (lock_ok) begin
               cnt_d   = '0;
               error_d = 1'b0;
               state_d = S_IDLE;
            end else if (lock_to) begin
               cnt_d   = '0;
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // error is visible in the same cycle as the timeout done pulse, then held by error_q.
   always_comb begin
      busy           = (state_q != S_IDLE);
      mgmt_write     = (state_q == S_WRITE);
      mgmt_address   = mgmt_write ? tbl_addr : 6'd0;
      mgmt_writedata = mgmt_write ? tbl_data : 32'd0;
      pll_reset      = (state_q == S_PRST);
      done           = lock_ok || lock_to;
      error          = error_q || (lock_to && !lock_ok);
   end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: event times and write contents are predicted arithmetically
// from the start cycle, per-write wait lengths and the lock rise cycle.
module tb_pll_reconfig_seq;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] cfg_m, cfg_k, cfg_c0;
   logic        busy, done, error;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_write;
   logic        mgmt_waitrequest;
   logic        pll_reset;
   logic        locked;

   int n_cmp = 0;
   int n_err = 0;
   int wt[8];
   logic [31:0] g_m, g_k, g_c0;
   bit prev_err = 1'b0;

   always #5 clk = ~clk;

   pll_reconfig_seq #(.LOCK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c0(cfg_c0),
      .busy(busy), .done(done), .error(error),
      .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
      .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
      .pll_reset(pll_reset), .locked(locked)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_write"}, mgmt_write, 0);
      chk({tag, "_addr"}, mgmt_address, 0);
      chk({tag, "_data"}, mgmt_writedata, 0);
      chk({tag, "_pllrst"}, pll_reset, 0);
   endtask

   // Called at a negedge with the DUT idle; relative cycle 0 is the start cycle.
   // rise_off places the locked rise relative to the first LOCK cycle.
   task automatic run_seq(input int rise_off, input bit mid_start, input bit abort_prst);
      int S[8];
      int A[8];
      int P0, L, R, D;
      bit to;
      logic [5:0]  ea[8];
      logic [31:0] ed[8];
      logic        e_wr, e_wait;
      logic [5:0]  e_addr;
      logic [31:0] e_data;
      logic        e_err;
      ea = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
      ed = '{32'h0, g_m, g_k, 32'h10000, g_c0, 32'h1, 32'h7, 32'h0};
      S[0] = 1;
      for (int i = 0; i < 8; i++) begin
         A[i] = S[i] + wt[i];
         if (i < 7) S[i+1] = A[i] + 8;
      end
      P0 = A[7] + 8;
      L  = P0 + 8;
      R  = L + rise_off;
      if (R < 0) R = 0;
      D  = (L + 4 > R + 2) ? L + 4 : R + 2;
      to = 1'b0;
      if (D > L + TO - 1) begin
         D  = L + TO - 1;
         to = 1'b1;
      end
      for (int c = 0; c <= D + 2; c++) begin
         e_wr = 1'b0; e_wait = 1'b0; e_addr = '0; e_data = '0;
         for (int i = 0; i < 8; i++) begin
            if (c >= S[i] && c <= A[i]) begin
               e_wr = 1'b1; e_addr = ea[i]; e_data = ed[i];
            end
            if (c >= S[i] && c < A[i]) e_wait = 1'b1;
         end
         e_err = (c == 0) ? prev_err : ((c < D) ? 1'b0 : to);
         chk("mgmt_write", mgmt_write, e_wr);
         chk("mgmt_address", mgmt_address, e_addr);
         chk("mgmt_writedata", mgmt_writedata, e_data);
         chk("pll_reset", pll_reset, (c >= P0 && c <= P0 + 7));
         chk("busy", busy, (c >= 1 && c <= D));
         chk("done", done, (c == D));
         chk("error", error, e_err);
         if (abort_prst && c == P0 + 3) begin
            rst_n = 1'b0;
            #1;
            chk("async_rst_pllrst", pll_reset, 0);
            chk("async_rst_busy", busy, 0);
            chk("async_rst_write", mgmt_write, 0);
            start = 1'b0; locked = 1'b0; mgmt_waitrequest = 1'b0;
            @(negedge clk);
            chk_all_zero("in_reset");
            rst_n = 1'b1;
            prev_err = 1'b0;
            @(negedge clk);
            return;
         end
         start  = (c == 0) || (mid_start && c == A[3] + 3) || (c == D);
         cfg_m  = (c == 0) ? g_m  : $urandom;
         cfg_k  = (c == 0) ? g_k  : $urandom;
         cfg_c0 = (c == 0) ? g_c0 : $urandom;
         mgmt_waitrequest = e_wait;
         locked = (c >= R);
         @(negedge clk);
      end
      start = 1'b0; locked = 1'b0; mgmt_waitrequest = 1'b0;
      prev_err = to;
      for (int c = 0; c < 3; c++) begin
         chk("idle_busy", busy, 0);
         chk("idle_error", error, prev_err);
         @(negedge clk);
      end
   endtask

   task automatic rand_cfg();
      g_m = $urandom; g_k = $urandom; g_c0 = $urandom;
   endtask

   task automatic zero_waits();
      for (int i = 0; i < 8; i++) wt[i] = 0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; locked = 1'b0; mgmt_waitrequest = 1'b0;
      cfg_m = '0; cfg_k = '0; cfg_c0 = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("after_reset");

      // zero-wait, locked rises T+74
      zero_waits();
      g_m = 32'h404; g_k = 32'hA3D709E8; g_c0 = 32'h20201;
      run_seq(1, 1'b0, 1'b0);

      // five wait cycles on the cfg_k write
      zero_waits(); wt[2] = 5; rand_cfg();
      run_seq(1, 1'b0, 1'b0);

      // lock never comes: timeout, error sticky until next start
      zero_waits(); rand_cfg();
      run_seq(100000, 1'b0, 1'b0);
      rand_cfg();
      run_seq(3, 1'b0, 1'b0);

      // start during GAP of write 3 is ignored
      zero_waits(); rand_cfg();
      run_seq(2, 1'b1, 1'b0);

      // reset during PRST, then a clean full sequence
      rand_cfg();
      run_seq(2, 1'b0, 1'b1);
      rand_cfg();
      run_seq(2, 1'b0, 1'b0);

      // locked high the whole time, including through PRST
      rand_cfg();
      run_seq(-100000, 1'b0, 1'b0);

      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 8; i++) wt[i] = $urandom_range(0, 3);
         rand_cfg();
         run_seq($urandom_range(0, 35) - 10, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
